// File: rtl/mem_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_inst_sequencer
// Description : Fetches instructions from a registered ROM and issues read,
//               shift, wait-for-interrupt and loop commands to the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_inst_sequencer #(
  parameter int INST_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [ITER_WIDTH-1:0] NUM_ITER,
  output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
  output logic                  ROM_ENABLE,
  input  logic [INST_WIDTH-1:0] ROM_DATA,
  output logic                  RD_REQ,
  input  logic                  RD_ACK,
  output logic                  SHIFT_VALID,
  input  logic                  SHIFT_READY,
  output logic [3:0]            SHIFT_AMOUNT,
  output logic [INST_WIDTH-9:0] SHIFT_LANES,
  input  logic                  WFI_RESUME,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam logic [3:0] c_OP_READ  = 4'b0000;
  localparam logic [3:0] c_OP_SHIFT = 4'b0101;
  localparam logic [3:0] c_OP_WFI   = 4'b0110;
  localparam logic [3:0] c_OP_LOOP  = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RD     = 3'd3,
    S_SH     = 3'd4,
    S_WFI    = 3'd5,
    S_LP     = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ITER_WIDTH-1:0] r_iter;
  logic [ITER_WIDTH-1:0] r_num_iter;
  logic [ITER_WIDTH-1:0] w_iter_inc;
  logic [3:0]            r_shift_amount;
  logic [INST_WIDTH-9:0] r_shift_lanes;
  logic                  r_done;
  logic                  r_error;
  logic                  w_start;
  logic                  w_pc_inc;
  logic                  w_pc_clr;
  logic                  w_load_instr;
  logic                  w_set_error;
  logic                  w_iter_step;
  logic                  w_done_set;
  logic [3:0]            w_op;

  assign w_iter_inc = r_iter + ITER_WIDTH'(1);
  assign w_op       = ROM_DATA[7:4];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_clr     = 1'b0;
    w_load_instr = 1'b0;
    w_set_error  = 1'b0;
    w_iter_step  = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_start      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        // Dispatch straight from ROM_DATA; the captured copy feeds the shift payload.
        w_load_instr = 1'b1;
        if (w_op == c_OP_READ && ROM_DATA[0]) begin
          w_next_state = S_RD;
        end else if (w_op == c_OP_SHIFT) begin
          w_next_state = S_SH;
        end else if (w_op == c_OP_WFI) begin
          w_next_state = S_WFI;
        end else if (w_op == c_OP_LOOP) begin
          w_next_state = S_LP;
        end else begin
          w_set_error  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_RD: begin
        if (RD_ACK) begin
          w_pc_inc     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_SH: begin
        if (SHIFT_READY) begin
          w_pc_inc     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_WFI: begin
        if (WFI_RESUME) begin
          w_pc_inc     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_LP: begin
        w_iter_step = 1'b1;
        if (w_iter_inc == r_num_iter) begin
          w_done_set   = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_pc_clr     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc           <= '0;
      r_iter         <= '0;
      r_num_iter     <= '0;
      r_shift_amount <= '0;
      r_shift_lanes  <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_start) begin
        r_pc       <= '0;
        r_iter     <= '0;
        r_error    <= 1'b0;
        // A request for zero passes runs the program once.
        r_num_iter <= (NUM_ITER == '0) ? ITER_WIDTH'(1) : NUM_ITER;
      end else begin
        if (w_pc_inc) begin
          r_pc <= r_pc + ADDR_WIDTH'(1);
        end else if (w_pc_clr) begin
          r_pc <= '0;
        end
        if (w_iter_step) begin
          r_iter <= w_iter_inc;
        end
        if (w_set_error) begin
          r_error <= 1'b1;
        end
      end
      if (w_load_instr) begin
        r_shift_amount <= ROM_DATA[3:0];
        r_shift_lanes  <= ROM_DATA[INST_WIDTH-1:8];
      end
    end
  end

  assign ROM_ADDRESS  = r_pc;
  assign ROM_ENABLE   = (r_state == S_FETCH);
  assign RD_REQ       = (r_state == S_RD);
  assign SHIFT_VALID  = (r_state == S_SH);
  assign SHIFT_AMOUNT = r_shift_amount;
  assign SHIFT_LANES  = r_shift_lanes;
  assign BUSY         = (r_state != S_IDLE);
  assign DONE         = r_done;
  assign ERROR        = r_error;

endmodule
`default_nettype wire
